// File: rtl/fp_ctrl_pkg.sv
// Shared types and constants for the fingerprint main controller.
// The optional FP_TIMEOUT_EN watchdog uses WDOG_W.
package fp_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAPT_T = 3'd1,
    CAPT_P = 3'd2,
    REQ    = 3'd3,
    WAIT   = 3'd4,
    NEXT   = 3'd5,
    FIN    = 3'd6
  } fp_fsm_e;

  localparam logic [1:0] FP_IDLE   = 2'b00;
  localparam logic [1:0] FP_ENROLL = 2'b01;
  localparam logic [1:0] FP_CMP    = 2'b10;

  localparam int WDOG_W = 24;

endpackage

// File: rtl/fp_main_ctrl_debounce.sv
// Key debouncer: 2-flop synchroniser, saturating stable-high counter and
// a single-cycle press pulse on the cycle the count reaches DEB_CYC.
module key_debounce #(
  parameter int DEB_CYC = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_i,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYC);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  // Counter advance and press detection
  always_comb begin
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d   = cnt_q + CNT_W'(1);
      press_d = (cnt_q == (CNT_MAX - CNT_W'(1)));
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser, counter and pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_i};
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/fp_main_ctrl.sv
// Fingerprint sequencer: enrols into a rotating set of N_TMPL slots and scans
// every valid template on a check. Define FP_TIMEOUT_EN for the watchdog/err port.
module fp_main_ctrl
  import fp_ctrl_pkg::*;
#(
  parameter int N_TMPL  = 2,
  parameter int DEB_CYC = 500000,
  parameter int SEL_W   = $clog2(N_TMPL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              update_in,
  input  logic              check_in,
  input  logic              capture_done,
  input  logic              fp_state,
  input  logic              fp_match,
  output logic [SEL_W-1:0]  write_sel,
  output logic [1:0]        fp_start,
  output logic [SEL_W-1:0]  cmp_idx,
  output logic [N_TMPL-1:0] tmpl_valid,
  output logic              busy,
  output logic              match_out,
  output logic              done
`ifdef FP_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam logic [SEL_W-1:0] LAST_SLOT  = SEL_W'(N_TMPL - 1);
  localparam logic [SEL_W-1:0] PROBE_SLOT = SEL_W'(N_TMPL);

  logic              upd_evt, chk_evt;
  fp_fsm_e           state_q, state_d;
  logic [SEL_W-1:0]  write_sel_q, write_sel_d;
  logic [SEL_W-1:0]  cmp_idx_q, cmp_idx_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [1:0]        fp_start_q, fp_start_d;
  logic [N_TMPL-1:0] valid_q, valid_d;
  logic              match_q, match_d;
  logic              done_q, done_d;
  logic [SEL_W:0]    first_s, next_s;

  // Lowest valid slot at or above start; MSB flags that one was found.
  function automatic logic [SEL_W:0] find_valid(input logic [N_TMPL-1:0] mask,
                                                input logic [SEL_W-1:0]  start);
    logic [SEL_W:0] res;
    res = '0;
    for (int i = N_TMPL - 1; i >= 0; i--) begin
      res = (mask[i] && (SEL_W'(i) >= start)) ? {1'b1, SEL_W'(i)} : res;
    end
    return res;
  endfunction

  assign first_s = find_valid(valid_q, '0);
  assign next_s  = find_valid(valid_q, cmp_idx_q + SEL_W'(1));

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_upd (
    .clk(clk), .rst(rst), .key_i(update_in), .press_o(upd_evt)
  );

  key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_chk (
    .clk(clk), .rst(rst), .key_i(check_in), .press_o(chk_evt)
  );

`ifdef FP_TIMEOUT_EN
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic              err_q, err_d;
  logic              wdog_act;
  assign wdog_act = (state_q == CAPT_T) || (state_q == CAPT_P) ||
                    (state_q == REQ)    || (state_q == WAIT);
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    write_sel_d = write_sel_q;
    cmp_idx_d   = cmp_idx_q;
    ptr_d       = ptr_q;
    fp_start_d  = FP_IDLE;
    valid_d     = valid_q;
    match_d     = match_q;
    done_d      = 1'b0;
`ifdef FP_TIMEOUT_EN
    wdog_d      = '0;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (upd_evt) begin
          write_sel_d = ptr_q;
          state_d     = CAPT_T;
        end else if (chk_evt) begin
          if (|valid_q) begin
            write_sel_d = PROBE_SLOT;
            state_d     = CAPT_P;
          end else begin
            done_d  = 1'b1;
            match_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CAPT_T: begin
        if (capture_done) begin
          valid_d    = valid_q | (N_TMPL'(1) << ptr_q);
          ptr_d      = (ptr_q == LAST_SLOT) ? '0 : ptr_q + SEL_W'(1);
          fp_start_d = FP_ENROLL;
          state_d    = IDLE;
        end else begin
          state_d = CAPT_T;
        end
      end
      CAPT_P: begin
        if (capture_done) begin
          match_d   = 1'b0;
          cmp_idx_d = first_s[SEL_W-1:0];
          state_d   = REQ;
        end else begin
          state_d = CAPT_P;
        end
      end
      REQ: begin
        if (fp_state) begin
          state_d = WAIT;
        end else begin
          fp_start_d = FP_CMP;
        end
      end
      WAIT: begin
        // Entered with fp_state high, so the first low sample is the fall.
        if (!fp_state) begin
          if (fp_match) begin
            match_d = 1'b1;
            state_d = FIN;
          end else begin
            state_d = NEXT;
          end
        end else begin
          state_d = WAIT;
        end
      end
      NEXT: begin
        if (next_s[SEL_W]) begin
          cmp_idx_d = next_s[SEL_W-1:0];
          state_d   = REQ;
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
`ifdef FP_TIMEOUT_EN
    if (wdog_act && (wdog_q == {WDOG_W{1'b1}})) begin
      state_d    = IDLE;
      fp_start_d = FP_IDLE;
      match_d    = 1'b0;
      done_d     = 1'b1;
      err_d      = 1'b1;
      valid_d    = valid_q;
      ptr_d      = ptr_q;
    end else begin
      err_d = 1'b0;
    end
    if (!wdog_act || (state_d != state_q)) begin
      wdog_d = '0;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      write_sel_q <= '0;
      cmp_idx_q   <= '0;
      ptr_q       <= '0;
      fp_start_q  <= FP_IDLE;
      valid_q     <= '0;
      match_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef FP_TIMEOUT_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      write_sel_q <= write_sel_d;
      cmp_idx_q   <= cmp_idx_d;
      ptr_q       <= ptr_d;
      fp_start_q  <= fp_start_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      done_q      <= done_d;
`ifdef FP_TIMEOUT_EN
      wdog_q      <= wdog_d;
      err_q       <= err_d;
`endif
    end
  end

  assign write_sel  = write_sel_q;
  assign fp_start   = fp_start_q;
  assign cmp_idx    = cmp_idx_q;
  assign tmpl_valid = valid_q;
  assign busy       = (state_q != IDLE);
  assign match_out  = match_q;
  assign done       = done_q;
`ifdef FP_TIMEOUT_EN
  assign err        = err_q;
`endif

endmodule

// File: tb/tb_fp_main_ctrl.sv
// Self-checking bench for fp_main_ctrl with N_TMPL=3, DEB_CYC=4; a small
// slot/pointer model plus a scripted comparator decides every expected value.
module tb_fp_main_ctrl;

  localparam int N   = 3;
  localparam int DEB = 4;
  localparam int SW  = 2;

  logic          clk = 1'b0;
  logic          rst, update_in, check_in, capture_done, fp_state, fp_match;
  logic [SW-1:0] write_sel, cmp_idx;
  logic [1:0]    fp_start;
  logic [N-1:0]  tmpl_valid;
  logic          busy, match_out, done;
`ifdef FP_TIMEOUT_EN
  logic          err;
`endif

  int checks = 0;
  int errors = 0;
  int m_valid = 0;
  int m_ptr   = 0;

  fp_main_ctrl #(.N_TMPL(N), .DEB_CYC(DEB)) dut (
    .clk(clk), .rst(rst), .update_in(update_in), .check_in(check_in),
    .capture_done(capture_done), .fp_state(fp_state), .fp_match(fp_match),
    .write_sel(write_sel), .fp_start(fp_start), .cmp_idx(cmp_idx),
    .tmpl_valid(tmpl_valid), .busy(busy), .match_out(match_out), .done(done)
`ifdef FP_TIMEOUT_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hold_keys(input logic u, input logic c, input int n);
    update_in = u;
    check_in  = c;
    cyc(n);
    update_in = 1'b0;
    check_in  = 1'b0;
  endtask

  function automatic logic cond(input int w);
    case (w)
      0:       return busy;
      1:       return (fp_start == 2'b10);
      2:       return done;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int w, input int limit);
    int k;
    k = 0;
    while (!cond(w) && k < limit) begin
      cyc(1);
      k++;
    end
    chk(tag, 32'(cond(w)), 32'd1);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ws"},    32'(write_sel),  32'd0);
    chk({tag, "_start"}, 32'(fp_start),   32'd0);
    chk({tag, "_idx"},   32'(cmp_idx),    32'd0);
    chk({tag, "_valid"}, 32'(tmpl_valid), 32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_match"}, 32'(match_out),  32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
  endtask

  task automatic do_enrol(input string tag, input logic with_chk);
    hold_keys(1'b1, with_chk, 6);
    wait_for({tag, "_busy"}, 0, 10);
    chk({tag, "_ws"}, 32'(write_sel), 32'(m_ptr));
    cyc(int'($urandom_range(0, 3)));
    chk({tag, "_pre_start"}, 32'(fp_start), 32'd0);
    capture_done = 1'b1;
    cyc(1);
    capture_done = 1'b0;
    m_valid = m_valid | (1 << m_ptr);
    m_ptr   = (m_ptr + 1) % N;
    chk({tag, "_start01"}, 32'(fp_start),   32'd1);
    chk({tag, "_valid"},   32'(tmpl_valid), 32'(m_valid));
    chk({tag, "_idle"},    32'(busy),       32'd0);
    cyc(1);
    chk({tag, "_start00"}, 32'(fp_start),   32'd0);
  endtask

  task automatic do_check(input string tag, input logic [N-1:0] mvec,
                          input int busy_len, input logic poke);
    int   slots[$];
    logic exp_match;
    int   seen;
    exp_match = 1'b0;
    for (int s = 0; s < N; s++) begin
      if (m_valid[s] && !exp_match) begin
        slots.push_back(s);
        if (mvec[s]) exp_match = 1'b1;
      end
    end
    hold_keys(1'b0, 1'b1, 6);
    wait_for({tag, "_busy"}, 0, 10);
    chk({tag, "_ws_probe"}, 32'(write_sel), 32'(N));
    cyc(int'($urandom_range(0, 2)));
    capture_done = 1'b1;
    cyc(1);
    capture_done = 1'b0;
    chk({tag, "_match_clr"}, 32'(match_out), 32'd0);
    foreach (slots[j]) begin
      wait_for({tag, "_req"}, 1, 10);
      chk({tag, "_idx"}, 32'(cmp_idx), 32'(slots[j]));
      cyc(int'($urandom_range(0, 2)));
      chk({tag, "_req_held"}, 32'(fp_start), 32'd2);
      fp_state = 1'b1;
      cyc(1);
      chk({tag, "_req_drop"}, 32'(fp_start), 32'd0);
      if (poke && j == 0) hold_keys(1'b0, 1'b1, 6);
      cyc(busy_len);
      fp_state = 1'b0;
      fp_match = mvec[slots[j]];
      cyc(1);
      fp_match = 1'b0;
    end
    wait_for({tag, "_done"}, 2, 10);
    chk({tag, "_match"}, 32'(match_out), 32'(exp_match));
    cyc(1);
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"},       32'(busy), 32'd0);
    if (poke) begin
      seen = 0;
      repeat (10) begin
        cyc(1);
        if (busy) seen++;
      end
      chk({tag, "_discarded"}, 32'(seen), 32'd0);
    end
  endtask

  initial begin
    int seen;
    int dcnt;
    int done_at;
    int bad_start;
    rst = 1'b1; update_in = 1'b0; check_in = 1'b0;
    capture_done = 1'b0; fp_state = 1'b0; fp_match = 1'b0;
    cyc(2);
    chk_reset("reset");
    rst = 1'b0;
    cyc(1);

    // A 3-cycle press is too short to register.
    hold_keys(1'b1, 1'b0, 3);
    seen = 0;
    repeat (10) begin
      cyc(1);
      if (busy) seen++;
    end
    chk("short_press", 32'(seen), 32'd0);

    // Check with no templates: immediate done, no match, no request.
    hold_keys(1'b0, 1'b1, 6);
    dcnt = 0; done_at = 0; bad_start = 0;
    for (int k = 1; k <= 3; k++) begin
      cyc(1);
      if (done) begin
        dcnt++;
        done_at = k;
      end
      if (fp_start != 2'b00) bad_start++;
    end
    chk("empty_done_cnt",  32'(dcnt),      32'd1);
    chk("empty_done_fast", 32'(done_at <= 2), 32'd1);
    chk("empty_start",     32'(bad_start), 32'd0);
    chk("empty_match",     32'(match_out), 32'd0);

    do_enrol("enrol0", 1'b0);
    do_enrol("enrol1", 1'b0);
    do_enrol("enrol2", 1'b0);
    do_enrol("enrol_wrap", 1'b0);

    do_check("scan_last", 3'b100, 1, 1'b0);
    do_check("scan_none", 3'b000, 2, 1'b0);
    for (int r = 0; r < 4; r++) begin
      do_check("rand", N'($urandom_range(0, 7)), int'($urandom_range(1, 4)), 1'b0);
    end

    do_enrol("both_keys", 1'b1);
    do_check("poke_wait", 3'b010, 2, 1'b1);

    // Reset asynchronously while the comparator is busy.
    hold_keys(1'b0, 1'b1, 6);
    wait_for("rst_busy", 0, 10);
    capture_done = 1'b1;
    cyc(1);
    capture_done = 1'b0;
    wait_for("rst_req", 1, 10);
    fp_state = 1'b1;
    cyc(2);
    #2 rst = 1'b1;
    #1 chk_reset("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    fp_state = 1'b0;
    m_valid = 0;
    m_ptr   = 0;
    cyc(1);
    do_enrol("post_rst", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_main_ctrl.md
Name: fp_main_ctrl

Overview:
- Next-generation fingerprint controller. Replaces the fixed two-template update/check selector with a parametrised sequencer.
- Supports N enrolment slots, debounced key inputs and a rotating enrol pointer.
- Runs a start/busy handshake with the comparison engine and scans every valid template during a check.
- Sits between the key inputs, the fingerprint image RAM write-select logic and the comparison block.

Parameters:
- N_TMPL, 2, number of template slots; slot N_TMPL is the probe (to-be-checked) image slot.
- DEB_CYC, 500000, cycles a key must be stable high before it counts as pressed (clk cycles, >=2).
- SEL_W, $clog2(N_TMPL+1), width of write_sel and cmp_idx (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- update_in  in  1  raw enrol key, active-high.
- check_in  in  1  raw check key, active-high.
- capture_done  in  1  one-cycle pulse when the image capture into the selected RAM slot finishes.
- fp_state  in  1  comparator busy; high while a comparison runs.
- fp_match  in  1  comparator result; valid on the cycle fp_state falls.
- write_sel  out  SEL_W  RAM slot being written: 0..N_TMPL-1 for templates, N_TMPL for the probe.
- fp_start  out  2  01 = enrol-complete pulse; 10 = compare request (held); 00 = idle.
- cmp_idx  out  SEL_W  template slot the current comparison uses.
- tmpl_valid  out  N_TMPL  bitmask of slots holding an enrolled template.
- busy  out  1  high in any state other than IDLE.
- match_out  out  1  last check result; sticky until the next check starts.
- done  out  1  one-cycle pulse when a check completes.

Behaviour:
- Reset values: write_sel=0, fp_start=00, cmp_idx=0, tmpl_valid=0, busy=0, match_out=0, done=0, enrol pointer=0, debounce counters=0, FSM=IDLE.
- Debounce: each key passes a 2-flop synchroniser, then a counter.
  - The counter clears whenever the synchronised level is low.
  - It saturates at DEB_CYC; a one-cycle press event fires on the cycle it reaches DEB_CYC.
  - The key must go low before it can fire again.
- Press events are acted on only in IDLE; events in other states are discarded, not queued.
- Simultaneous update and check events: update wins, check is dropped.
- FSM states:
  - IDLE:
    - update event: write_sel<=enrol pointer, go to CAPT_T.
    - check event with tmpl_valid!=0: write_sel<=N_TMPL, go to CAPT_P.
    - check event with tmpl_valid==0: pulse done with match_out=0, stay in IDLE.
  - CAPT_T: wait for capture_done, then:
    - set tmpl_valid[ptr];
    - ptr<=ptr+1, wrapping N_TMPL-1 -> 0 (the oldest template is overwritten);
    - drive fp_start=01 for exactly one cycle;
    - go to IDLE.
  - CAPT_P: on capture_done, clear match_out, set cmp_idx to the lowest valid slot, go to REQ.
  - REQ: drive fp_start=10 until fp_state is sampled high, then fp_start<=00 and go to WAIT. There is no timeout without the optional feature.
  - WAIT: on the falling edge of fp_state (sampled), go to NEXT.
    - fp_match=1: match_out<=1, go to FIN early (remaining slots are skipped).
  - NEXT: advance cmp_idx to the next higher valid slot and go to REQ; if none remain, go to FIN.
  - FIN: pulse done for one cycle, go to IDLE.
- write_sel holds its value outside capture states (RAM mux stays stable).
- Reset asserted mid-operation: immediate return to reset values; tmpl_valid is cleared too (templates are considered lost).
- Latency: fp_start=01 appears on the cycle after the capture_done sample. A compare request is raised 1 cycle after entering REQ.

Optional Feature:
- Macro: FP_TIMEOUT_EN.
- When defined:
  - a 24-bit watchdog counts in CAPT_T, CAPT_P, REQ and WAIT;
  - it clears on every state change;
  - on reaching 2^24-1: fp_start<=00, match_out<=0, done pulses, FSM goes to IDLE;
  - tmpl_valid is unchanged; a timed-out enrol does not advance the pointer.
  - An extra output port err (1 bit) pulses alongside done on a timeout.
- When undefined: no counter and no err port; all waits are unbounded.

Decomposition:
- Package fp_ctrl_pkg:
  - FSM state enum (IDLE, CAPT_T, CAPT_P, REQ, WAIT, NEXT, FIN);
  - fp_start encodings FP_IDLE=2'b00, FP_ENROLL=2'b01, FP_CMP=2'b10;
  - watchdog width constant.
- Sub-module key_debounce (synchroniser + counter + press pulse), instantiated twice, parameter DEB_CYC.
- The next-valid-slot search is a combinational function in the main module.

Test Plan:
- DEB_CYC=4, update_in high for 3 cycles then low -> no event; high for 6 cycles -> exactly one press event, FSM goes to CAPT_T.
- N_TMPL=3, three enrols, each closed by capture_done -> write_sel 0,1,2; tmpl_valid 001,011,111; three single-cycle fp_start=01 pulses. A fourth enrol -> write_sel=0.
- tmpl_valid=101, check, capture_done; comparator answers slot 0 no-match and slot 2 match -> cmp_idx 0 then 2, fp_start=10 held until fp_state rises, match_out=1, done pulses once.
- Check with tmpl_valid=000 -> done pulse within 2 cycles of the event, match_out=0, fp_start never leaves 00.
- update and check events on the same cycle -> enrol path taken, check ignored. A check pressed during WAIT -> discarded.
- rst asserted during WAIT -> all outputs return to reset values asynchronously. With FP_TIMEOUT_EN and fp_state stuck high -> err and done pulse after 2^24-1 cycles, then IDLE.
